// File: rtl/regfile_sb_pkg.sv
// Shared defaults and helpers for the scoreboarded register file.
package regfile_sb_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int NRD_DEF  = 2;

    function automatic int aw_of(input int nreg);
        return (nreg < 2) ? 1 : $clog2(nreg);
    endfunction

    localparam int AW_DEF = aw_of(NREG_DEF);

    localparam logic [XLEN_DEF-1:0] REG_ZERO = '0;

endpackage

// File: rtl/regfile_sb_rdport.sv
// One read port: zero/enable gating, write-back bypass and hazard flag.
module regfile_sb_rdport #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic                       rst,
    input  logic                       re,
    input  logic [AW-1:0]              raddr,
    input  logic [NREG-1:0][XLEN-1:0]  regs,
    input  logic [NREG-1:0]            busy,
    input  logic                       we,
    input  logic [AW-1:0]              waddr,
    input  logic [XLEN-1:0]            wdata,
    output logic [XLEN-1:0]            rdata,
    output logic                       rbusy
);

    logic hit;
    logic byp;

    // raddr != 0 also guarantees the bypass never fires for x0
    assign hit = rst && re && (raddr != '0);
    assign byp = we && (waddr == raddr);

    always_comb begin
        rdata = '0;
        rbusy = 1'b0;
        if (hit) begin
            rdata = byp ? wdata : regs[raddr];
            rbusy = busy[raddr] && !byp;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Register file with per-register busy scoreboard, combinational reads and bypass.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter  int XLEN = XLEN_DEF,
    parameter  int NREG = NREG_DEF,
    parameter  int NRD  = NRD_DEF,
    localparam int AW   = aw_of(NREG)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NRD-1:0]       re,
    input  logic [NRD*AW-1:0]    raddr,
    output logic [NRD*XLEN-1:0]  rdata,
    output logic [NRD-1:0]       rbusy,
    output logic                 stall,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic [XLEN-1:0]      wdata,
    input  logic                 claim,
    input  logic [AW-1:0]        claim_addr
);

    logic [NREG-1:0][XLEN-1:0] regs_q, regs_d;
    logic [NREG-1:0]           busy_q, busy_d;
    logic                      wr_en;
    logic                      clm_en;

    assign wr_en  = we && (waddr != '0);
    assign clm_en = claim && (claim_addr != '0);

    // Claim is applied after clear so a same-register collision ends busy
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (wr_en) begin
            regs_d[waddr] = wdata;
            busy_d[waddr] = 1'b0;
        end
        if (clm_en) begin
            busy_d[claim_addr] = 1'b1;
        end
        regs_d[0] = XLEN'(REG_ZERO);
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs_q <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        regfile_sb_rdport #(
            .XLEN(XLEN),
            .NREG(NREG),
            .AW  (AW)
        ) u_rdport (
            .rst  (rst),
            .re   (re[k]),
            .raddr(raddr[k*AW +: AW]),
            .regs (regs_q),
            .busy (busy_q),
            .we   (we),
            .waddr(waddr),
            .wdata(wdata),
            .rdata(rdata[k*XLEN +: XLEN]),
            .rbusy(rbusy[k])
        );
    end

    assign stall = |rbusy;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench: default 2-port instance plus a 4-port/64-bit/16-register instance.
module tb_regfile_sb;

    logic clk;
    logic rst;

    logic [1:0]   re_a;
    logic [9:0]   raddr_a;
    logic [63:0]  rdata_a;
    logic [1:0]   rbusy_a;
    logic         stall_a;
    logic         we_a;
    logic [4:0]   waddr_a;
    logic [31:0]  wdata_a;
    logic         claim_a;
    logic [4:0]   claim_addr_a;

    logic [3:0]   re_b;
    logic [15:0]  raddr_b;
    logic [255:0] rdata_b;
    logic [3:0]   rbusy_b;
    logic         stall_b;
    logic         we_b;
    logic [3:0]   waddr_b;
    logic [63:0]  wdata_b;
    logic         claim_b;
    logic [3:0]   claim_addr_b;

    int checks   = 0;
    int failures = 0;

    regfile_sb u_dut_a (
        .clk(clk), .rst(rst), .re(re_a), .raddr(raddr_a), .rdata(rdata_a),
        .rbusy(rbusy_a), .stall(stall_a), .we(we_a), .waddr(waddr_a),
        .wdata(wdata_a), .claim(claim_a), .claim_addr(claim_addr_a)
    );

    regfile_sb #(.XLEN(64), .NREG(16), .NRD(4)) u_dut_b (
        .clk(clk), .rst(rst), .re(re_b), .raddr(raddr_b), .rdata(rdata_b),
        .rbusy(rbusy_b), .stall(stall_b), .we(we_b), .waddr(waddr_b),
        .wdata(wdata_b), .claim(claim_b), .claim_addr(claim_addr_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] wb(input int k);
        return {32'hC0DE0000 + k, 32'h0000F000 + k};
    endfunction

    initial begin
        rst = 1'b0;
        re_a = '0; raddr_a = '0; we_a = 1'b0; waddr_a = '0; wdata_a = '0;
        claim_a = 1'b0; claim_addr_a = '0;
        re_b = '0; raddr_b = '0; we_b = 1'b0; waddr_b = '0; wdata_b = '0;
        claim_b = 1'b0; claim_addr_b = '0;

        // Reset state, with a bypass-capable write presented during reset
        #2;
        re_a = 2'b11; raddr_a = {5'd5, 5'd5};
        we_a = 1'b1; waddr_a = 5'd5; wdata_a = 32'hAAAA5555;
        #1;
        chk("rst_rdata", rdata_a, 64'h0);
        chk("rst_stall", stall_a, 1'b0);
        we_a = 1'b0;
        #9 rst = 1'b1;
        step();

        // Write x5, claim x6, then reset between edges
        we_a = 1'b1; waddr_a = 5'd5; wdata_a = 32'h1234;
        claim_a = 1'b1; claim_addr_a = 5'd6;
        re_a = 2'b00;
        step();
        we_a = 1'b0; claim_a = 1'b0;
        re_a = 2'b11; raddr_a = {5'd6, 5'd5};
        #1;
        chk("x5_written", rdata_a[31:0], 32'h1234);
        chk("x6_busy_stall", stall_a, 1'b1);
        rst = 1'b0;
        #1;
        chk("midrst_rdata", rdata_a, 64'h0);
        chk("midrst_stall", stall_a, 1'b0);
        #1 rst = 1'b1;
        #1;
        chk("postrst_x5", rdata_a[31:0], 32'h0);
        chk("postrst_rbusy", rbusy_a, 2'b00);
        step();

        // Bypass
        we_a = 1'b1; waddr_a = 5'd7; wdata_a = 32'hDEADBEEF;
        re_a = 2'b01; raddr_a = {5'd0, 5'd7};
        #1;
        chk("bypass_same", rdata_a[31:0], 32'hDEADBEEF);
        step();
        we_a = 1'b0; wdata_a = '0;
        #1;
        chk("bypass_next", rdata_a[31:0], 32'hDEADBEEF);
        re_a = 2'b00;
        #1;
        chk("re_off_zero", rdata_a, 64'h0);
        step();

        // x0 is immutable and never busy
        we_a = 1'b1; waddr_a = 5'd0; wdata_a = 32'hFFFFFFFF;
        claim_a = 1'b1; claim_addr_a = 5'd0;
        re_a = 2'b11; raddr_a = {5'd0, 5'd0};
        #1;
        chk("x0_same_rdata", rdata_a, 64'h0);
        step();
        we_a = 1'b0; claim_a = 1'b0;
        #1;
        chk("x0_rdata", rdata_a, 64'h0);
        chk("x0_rbusy", rbusy_a, 2'b00);
        chk("x0_stall", stall_a, 1'b0);
        step();

        // Hazard on x3: claim at N, write-back at N+3
        claim_a = 1'b1; claim_addr_a = 5'd3;
        re_a = 2'b01; raddr_a = {5'd0, 5'd3};
        #1;
        chk("hz_n_rbusy", rbusy_a, 2'b00);
        step();
        claim_a = 1'b0;
        #1;
        chk("hz_n1_rbusy", rbusy_a, 2'b01);
        chk("hz_n1_stall", stall_a, 1'b1);
        step();
        chk("hz_n2_stall", stall_a, 1'b1);
        step();
        we_a = 1'b1; waddr_a = 5'd3; wdata_a = 32'h55;
        #1;
        chk("hz_n3_stall", stall_a, 1'b0);
        chk("hz_n3_rdata", rdata_a[31:0], 32'h55);
        step();
        we_a = 1'b0;
        #1;
        chk("hz_n4_stall", stall_a, 1'b0);
        chk("hz_n4_rdata", rdata_a[31:0], 32'h55);
        step();

        // Collision on x9: claim and write-back in the same cycle
        claim_a = 1'b1; claim_addr_a = 5'd9;
        step();
        claim_a = 1'b0;
        re_a = 2'b10; raddr_a = {5'd9, 5'd0};
        #1;
        chk("col_pre_rbusy", rbusy_a, 2'b10);
        claim_a = 1'b1; claim_addr_a = 5'd9;
        we_a = 1'b1; waddr_a = 5'd9; wdata_a = 32'hA5A5;
        step();
        claim_a = 1'b0; we_a = 1'b0;
        #1;
        chk("col_rbusy", rbusy_a, 2'b10);
        chk("col_rdata", rdata_a[63:32], 32'hA5A5);
        chk("col_stall", stall_a, 1'b1);

        // Clear x9 while claiming x10
        we_a = 1'b1; waddr_a = 5'd9; wdata_a = 32'h77;
        claim_a = 1'b1; claim_addr_a = 5'd10;
        step();
        we_a = 1'b0; claim_a = 1'b0;
        re_a = 2'b11; raddr_a = {5'd10, 5'd9};
        #1;
        chk("dual_rbusy", rbusy_a, 2'b10);
        chk("dual_rdata", rdata_a[31:0], 32'h77);
        raddr_a = {5'd9, 5'd9};
        #1;
        chk("same_addr", {rbusy_a, rdata_a}, {2'b00, 32'h77, 32'h77});

        // Repeated claim of x10 does not count; one write-back clears it
        claim_a = 1'b1; claim_addr_a = 5'd10;
        step();
        step();
        claim_a = 1'b0;
        we_a = 1'b1; waddr_a = 5'd10; wdata_a = 32'h10;
        step();
        we_a = 1'b0;
        raddr_a = {5'd10, 5'd12};
        #1;
        chk("reclaim_rbusy", rbusy_a, 2'b00);
        chk("reclaim_rdata", rdata_a[63:32], 32'h10);

        // Write to a non-busy register leaves busy clear
        we_a = 1'b1; waddr_a = 5'd12; wdata_a = 32'hBEEF;
        step();
        we_a = 1'b0;
        #1;
        chk("nb_write", {rbusy_a, rdata_a}, {2'b00, 32'h10, 32'hBEEF});
        re_a = 2'b00;

        // Wide configuration: four ports, busy only on port 3
        for (int k = 1; k <= 4; k++) begin
            we_b = 1'b1; waddr_b = 4'(k); wdata_b = wb(k);
            step();
        end
        we_b = 1'b0;
        claim_b = 1'b1; claim_addr_b = 4'd4;
        step();
        claim_b = 1'b0;
        re_b = 4'b1111; raddr_b = {4'd4, 4'd3, 4'd2, 4'd1};
        #1;
        chk("b_rdata", rdata_b, {64'hC0DE00040000F004, 64'hC0DE00030000F003,
                                 64'hC0DE00020000F002, 64'hC0DE00010000F001});
        chk("b_rbusy", rbusy_b, 4'b1000);
        chk("b_stall", stall_b, 1'b1);
        re_b = 4'b0111;
        #1;
        chk("b_mask_stall", stall_b, 1'b0);
        chk("b_mask_rdata", rdata_b, {64'h0, 64'hC0DE00030000F003,
                                      64'hC0DE00020000F002, 64'hC0DE00010000F001});
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter XLEN, default 32, data width of each register.
REQ-002 Parameter NREG, default 32, number of architectural registers; power of two, at least 2.
REQ-003 Parameter NRD, default 2, number of read ports, range 1..4.
REQ-004 Derived constant AW = clog2(NREG), register address width.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, asynchronous and active-low.
REQ-007 re  in  NRD  per-port read enable.
REQ-008 raddr  in  NRD*AW  per-port read address; port k occupies bits [k*AW +: AW].
REQ-009 rdata  out  NRD*XLEN  per-port read data; port k occupies bits [k*XLEN +: XLEN].
REQ-010 rbusy  out  NRD  per-port flag: addressed register has an outstanding producer.
REQ-011 stall  out  1  OR of rbusy over all ports with re set.
REQ-012 we  in  1  write-back enable.
REQ-013 waddr  in  AW  write-back address.
REQ-014 wdata  in  XLEN  write-back data.
REQ-015 claim  in  1  issue-stage claim: the instruction entering EX will write claim_addr.
REQ-016 claim_addr  in  AW  register being claimed.

Function
REQ-017 Read ports are combinational; there is no read latency.
REQ-018 rdata for port k is 0 when re[k]=0, when raddr=0, or when rst is low.
REQ-019 Write: when we=1 and waddr!=0, reg[waddr] takes wdata at the next rising edge.
REQ-020 Writes to register 0 are discarded; register 0 always reads 0 and is never busy.
REQ-021 Bypass: when we=1, waddr=raddr[k], waddr!=0 and re[k]=1, rdata[k] equals wdata in the same cycle.
REQ-022 Scoreboard: one busy bit per register, NREG bits in total; bit 0 is tied to 0.
REQ-023 Claim: when claim=1 and claim_addr!=0, busy[claim_addr] is set at the next edge.
REQ-024 Clear: when we=1 and waddr!=0, busy[waddr] is cleared at the next edge.
REQ-025 If claim and clear target the same register in one cycle, the claim wins and the bit ends set.
REQ-026 Claim and clear of different registers in the same cycle both take effect.
REQ-027 rbusy[k] = re[k] AND busy[raddr[k]] AND NOT (we AND waddr=raddr[k]). A same-cycle write-back resolves the hazard through the bypass.
REQ-028 A claim becomes visible on rbusy in the cycle after it is presented, not in the same cycle.
REQ-029 A repeated claim of an already busy register keeps the bit set; no counting.
REQ-030 A write to a register that is not busy performs the data update only; the busy bit stays 0.
REQ-031 stall = OR over k of rbusy[k]; it is 0 while rst is low.
REQ-032 All read ports operate independently; the same address on several ports returns identical data and flags.

Reset
REQ-033 While rst is low, all registers and all busy bits are cleared immediately, without waiting for clk.
REQ-034 While rst is low, rdata, rbusy and stall are 0 on every port.
REQ-035 A reset asserted mid-operation discards pending claims and in-flight writes; the first edge after release performs normal updates.

Structure
REQ-036 The shared package holds XLEN, NREG and NRD defaults, the AW derivation, and the default-zero constant for register data.
REQ-037 Sub-module regfile_sb_rdport holds one port's address decode, zero/enable gating, bypass mux and rbusy logic; it is instantiated NRD times.
REQ-038 The register array, the busy vector and the stall reduction reside in regfile_sb.

Verification
REQ-039 Reset: write x5=0x1234, then pulse rst low between edges -> rdata and stall are 0 immediately; after release, read x5 -> 0.
REQ-040 Bypass: we=1, waddr=7, wdata=0xDEADBEEF, re[0]=1, raddr[0]=7 in one cycle -> rdata[0]=0xDEADBEEF that cycle; the next cycle with we=0 still reads 0xDEADBEEF.
REQ-041 x0: write 0xFFFFFFFF to x0, claim x0 -> rdata=0 and rbusy=0 on every port thereafter.
REQ-042 Hazard: claim x3 at cycle N; read x3 at N+1 -> stall=1; write-back x3=0x55 at N+3 -> that cycle stall=0 and rdata=0x55; at N+4 busy is clear.
REQ-043 Collision: busy x9 set; claim x9 and we to x9 in the same cycle -> next cycle a read of x9 shows rbusy=1 and the new data.
REQ-044 Parameters: NRD=4, XLEN=64, NREG=16 -> four ports read distinct registers; a busy register on port 3 only gives stall=1, and re[3]=0 masks it to stall=0.
